// File: rtl/wb_rgb_pwm_pkg.sv
// rtl/wb_rgb_pwm_pkg.sv - shared register map, control bit indices and blink state type
package wb_rgb_pwm_pkg;

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_DUTY     = 4'h1;
  localparam logic [3:0] REG_BLINK    = 4'h2;
  localparam logic [3:0] REG_PRESCALE = 4'h3;
  localparam logic [3:0] REG_STATUS   = 4'h4;

  localparam int CTRL_EN_LSB   = 0;
  localparam int CTRL_BLINK_EN = 3;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_state_t;

endpackage

// File: rtl/wb_rgb_pwm_if.sv
// rtl/wb_rgb_pwm_if.sv - Wishbone classic single-access bus bundle
interface wb_rgb_pwm_if #(
  parameter int ADDR_W = 24
);
  logic              i_wb_cyc;
  logic              i_wb_stb;
  logic              i_wb_we;
  logic [ADDR_W-1:0] i_wb_adr;
  logic [31:0]       i_wb_dat;
  logic              o_wb_ack;
  logic [31:0]       o_wb_dat;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    input  o_wb_ack, o_wb_dat
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat,
    output o_wb_ack, o_wb_dat
  );
endinterface

// File: rtl/wb_rgb_pwm_channel.sv
// rtl/wb_rgb_pwm_channel.sv - one PWM lane: shadowed duty, compare and registered output
module rgb_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic                wrap_i,
  input  logic                duty_we_i,
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic                en_i,
  input  logic                phase_i,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                pwm_o
);

  logic [PWM_BITS-1:0] shadow_q, shadow_d;
  logic [PWM_BITS-1:0] active_q, active_d;
  logic                pwm_q, pwm_d;

  // wrap_i marks the last count of a period, so the new duty is live exactly at count 0
  always_comb begin
    shadow_d = duty_we_i ? duty_i : shadow_q;
    active_d = wrap_i ? shadow_q : active_q;
    pwm_d    = en_i & phase_i & (cnt_i < active_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign duty_o = shadow_q;
  assign pwm_o  = pwm_q;

endmodule

// File: rtl/wb_rgb_pwm.sv
// rtl/wb_rgb_pwm.sv - Wishbone RGB PWM slave: register decode, prescaler, blink envelope
module wb_rgb_pwm
  import wb_rgb_pwm_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int PWM_BITS = 8,
  parameter int TICK_W   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_rgb_pwm_if.slave   wb,
  output logic [2:0]    pwm_out,
  output logic          blink_phase
);

  localparam logic [TICK_W:0] PH_ONE = (TICK_W+1)'(1);

  logic                ack_q;
  logic [31:0]         dat_q;
  logic [3:0]          ctrl_q;
  logic [TICK_W-1:0]   blink_on_q, blink_off_q, prescale_q;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [TICK_W-1:0]   pre_q, pre_d, ph_q, ph_d, limit;
  logic [TICK_W:0]     ph_inc;
  blink_state_t        state_q, state_d;
  logic [PWM_BITS-1:0] duty_sh [3];
  logic [31:0]         rd_data;
  logic [3:0]          adr;
  logic                req, wr, duty_we, wrap, tick, blink_en;
  logic                unused_adr_hi;

  assign adr           = wb.i_wb_adr[3:0];
  assign unused_adr_hi = ^wb.i_wb_adr[ADDR_W-1:4];
  assign req           = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
  assign wr            = req & wb.i_wb_we;
  assign duty_we       = wr & (adr == REG_DUTY);
  assign blink_en      = ctrl_q[CTRL_BLINK_EN];
  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_dat   = dat_q;

  always_comb begin
    rd_data = '0;
    case (adr)
      REG_CTRL:     rd_data[3:0] = ctrl_q;
      REG_DUTY: begin
        rd_data[0  +: PWM_BITS] = duty_sh[0];
        rd_data[8  +: PWM_BITS] = duty_sh[1];
        rd_data[16 +: PWM_BITS] = duty_sh[2];
      end
      REG_BLINK: begin
        rd_data[0  +: TICK_W] = blink_on_q;
        rd_data[16 +: TICK_W] = blink_off_q;
      end
      REG_PRESCALE: rd_data[0 +: TICK_W] = prescale_q;
      REG_STATUS: begin
        rd_data[0]            = blink_phase;
        rd_data[8 +: PWM_BITS] = cnt_q;
      end
      default:      rd_data = '0;
    endcase
  end

  // ack_q masks the request so a held strobe gets one access per ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ctrl_q      <= '0;
      blink_on_q  <= '0;
      blink_off_q <= '0;
      prescale_q  <= '1;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rd_data;
      if (wr) begin
        case (adr)
          REG_CTRL:     ctrl_q <= wb.i_wb_dat[3:0];
          REG_BLINK: begin
            blink_on_q  <= wb.i_wb_dat[0  +: TICK_W];
            blink_off_q <= wb.i_wb_dat[16 +: TICK_W];
          end
          REG_PRESCALE: prescale_q <= wb.i_wb_dat[0 +: TICK_W];
          default:      ;
        endcase
      end
    end
  end

  assign cnt_d = cnt_q + PWM_BITS'(1);
  assign wrap  = (cnt_q == '1);

  for (genvar i = 0; i < 3; i++) begin : g_ch
    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt_i     (cnt_q),
      .wrap_i    (wrap),
      .duty_we_i (duty_we),
      .duty_i    (wb.i_wb_dat[8*i +: PWM_BITS]),
      .en_i      (ctrl_q[CTRL_EN_LSB+i]),
      .phase_i   (blink_phase),
      .duty_o    (duty_sh[i]),
      .pwm_o     (pwm_out[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pre_q   <= '0;
      ph_q    <= '0;
      state_q <= BLINK_ON;
    end else begin
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      ph_q    <= ph_d;
      state_q <= state_d;
    end
  end

  // >= rather than == so a limit lowered below the running count still fires
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    pre_d   = pre_q;
    tick    = (pre_q >= prescale_q);
    limit   = (state_q == BLINK_ON) ? blink_on_q : blink_off_q;
    ph_inc  = {1'b0, ph_q} + PH_ONE;
    if (!blink_en) begin
      state_d = BLINK_ON;
      ph_d    = '0;
      pre_d   = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + TICK_W'(1);
      if (tick) begin
        if (ph_inc >= {1'b0, limit}) begin
          state_d = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
          ph_d    = '0;
        end else begin
          ph_d = ph_inc[TICK_W-1:0];
        end
      end
    end
  end

  // A zero limit pins the envelope: zero on-time is always dark, zero off-time always lit
  always_comb begin
    blink_phase = 1'b1;
    if (blink_en) begin
      if (blink_on_q == '0)       blink_phase = 1'b0;
      else if (blink_off_q == '0) blink_phase = 1'b1;
      else                        blink_phase = (state_q == BLINK_ON);
    end
  end

endmodule
